// File: rtl/interleaver_sel_seq_pkg.sv
// Shared definitions for the block interleaver address sequencer.
// It holds the FSM state type and the default array geometry.
package interleaver_sel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam int DEFAULT_ROWS = 12;
    localparam int DEFAULT_COLS = 8;

endpackage

// File: rtl/interleaver_sel_seq_onehot_dec.sv
// Binary-to-one-hot decoder with enable. The output is all zero when the
// decoder is disabled or when the index is out of range (idx >= N).
module onehot_dec #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] idx_i,
    input  logic          en_i,
    output logic [N-1:0]  onehot_o
);

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (int'(idx_i) == i);
        end
    end

endmodule

// File: rtl/interleaver_sel_seq.sv
// Row/column address sequencer for a ROWS x COLS block interleaver.
// Frames are filled row-major in WRITE and drained column-major in READ.
module interleaver_sel_seq
    import interleaver_sel_seq_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROWS-1:0]          row_sel,
    output logic [$clog2(COLS)-1:0]  col_idx,
    output logic                     mode,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            r_d     = '0;
            c_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WRITE;
                        r_d     = '0;
                        c_d     = '0;
                    end
                end
                WRITE: begin
                    // in_ready is constant high here, so in_valid alone is the handshake.
                    if (in_valid) begin
                        if (c_q == C_LAST) begin
                            c_d = '0;
                            if (r_q == R_LAST) begin
                                r_d     = '0;
                                state_d = READ;
                            end else begin
                                r_d = r_q + RW'(1);
                            end
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
                READ: begin
                    if (out_ready) begin
                        if (r_q == R_LAST) begin
                            r_d = '0;
                            if (c_q == C_LAST) begin
                                c_d     = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                c_d = c_q + CW'(1);
                            end
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    r_d     = '0;
                    c_d     = '0;
                end
            endcase
        end
    end

    // Decoding the next row pointer lets row_sel come straight from a flop.
    onehot_dec #(
        .N (ROWS)
    ) u_row_dec (
        .idx_i    (r_d),
        .en_i     (state_d != IDLE),
        .onehot_o (row_sel_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            c_q       <= '0;
            row_sel_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            row_sel_q <= row_sel_d;
            done_q    <= done_d;
        end
    end

    assign row_sel   = row_sel_q;
    assign col_idx   = c_q;
    assign in_ready  = (state_q == WRITE);
    assign out_valid = (state_q == READ);
    assign mode      = (state_q == READ);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_interleaver_sel_seq.sv
// Self-checking bench: a 3x4 sequencer against an address-order model, plus a
// default-geometry (12x8) instance for the full-size frame.
module tb_interleaver_sel_seq;

    localparam int R  = 3;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int BR = 12;
    localparam int BC = 8;
    localparam int BN = BR * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, abort, in_valid, out_ready;
    logic         in_ready, out_valid, mode, busy, done;
    logic [R-1:0] row_sel;
    logic [1:0]   col_idx;

    logic          b_start, b_abort, b_in_valid, b_out_ready;
    logic          b_in_ready, b_out_valid, b_mode, b_busy, b_done;
    logic [BR-1:0] b_row_sel;
    logic [2:0]    b_col_idx;

    int n_checks = 0;
    int n_fail   = 0;

    interleaver_sel_seq #(.ROWS(R), .COLS(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_sel   (row_sel),
        .col_idx   (col_idx),
        .mode      (mode),
        .busy      (busy),
        .done      (done)
    );

    interleaver_sel_seq dut_big (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .abort     (b_abort),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .row_sel   (b_row_sel),
        .col_idx   (b_col_idx),
        .mode      (b_mode),
        .busy      (b_busy),
        .done      (b_done)
    );

    // Observed output bundle: {busy, mode, in_ready, out_valid, done, row_sel, col_idx}.
    function automatic logic [9:0] obs();
        return {busy, mode, in_ready, out_valid, done, row_sel, col_idx};
    endfunction

    // Expected bundle for beat k of a frame: beats 0..N-1 fill row-major,
    // beats N..2N-1 drain column-major; inactive means the idle outputs.
    function automatic logic [9:0] model_out(input int k, input bit active, input bit done_exp);
        logic [2:0] rs;
        logic [1:0] ci;
        int         j;
        if (!active) return {4'b0000, done_exp, 5'b00000};
        if (k < N) begin
            rs = 3'(1 << (k / C));
            ci = 2'(k % C);
            return {4'b1010, 1'b0, rs, ci};
        end
        j  = k - N;
        rs = 3'(1 << (j % R));
        ci = 2'(j / R);
        return {4'b1101, 1'b0, rs, ci};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        b_start = 1'b1; b_abort = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== model_out(0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset_hold: got %b expected %b", obs(), model_out(0, 0, 0));
            end
        end
        n_checks++;
        if ({b_busy, b_done, b_row_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_big: got busy=%b done=%b row_sel=%b expected all zero", b_busy, b_done, b_row_sel);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; b_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== model_out(0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset_no_start: got %b expected %b", obs(), model_out(0, 0, 0));
            end
        end
    endtask

    // Runs one frame from a start pulse. stop_at >= 0 injects abort (or rst)
    // while the frame sits at that beat; poke_start toggles start mid-frame.
    task automatic run_frame(input string tag, input int vpct, input int rpct,
                             input int stop_at, input bit stop_rst, input bit poke_start);
        int         k, cyc, wr_seen, rd_seen;
        bit         acc;
        logic [9:0] exp;
        k = 0; cyc = 0; wr_seen = 0; rd_seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (k < 2 * N) begin
            exp = model_out(k, 1, 0);
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL %s beat=%0d: got %b expected %b", tag, k, obs(), exp);
            end
            if (k == stop_at) begin
                if (stop_rst) rst = 1'b1;
                else          abort = 1'b1;
                in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
                @(negedge clk);
                rst = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
                repeat (3) begin
                    n_checks++;
                    if (obs() !== model_out(0, 0, 0)) begin
                        n_fail++;
                        $display("FAIL %s after_stop: got %b expected %b", tag, obs(), model_out(0, 0, 0));
                    end
                    @(negedge clk);
                end
                return;
            end
            in_valid  = (int'($urandom_range(99)) < vpct);
            out_ready = (int'($urandom_range(99)) < rpct);
            if (poke_start) start = ($urandom_range(3) == 0);
            acc = (k < N) ? in_valid : out_ready;
            if (in_valid && in_ready)   wr_seen++;
            if (out_valid && out_ready) rd_seen++;
            @(negedge clk);
            if (acc) k++;
            cyc++;
            if (cyc > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got %0d beats expected %0d", tag, k, 2 * N);
                break;
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (obs() !== model_out(0, 0, 1)) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b expected %b", tag, obs(), model_out(0, 0, 1));
        end
        n_checks++;
        if (wr_seen != N || rd_seen != N) begin
            n_fail++;
            $display("FAIL %s beat_count: got wr=%0d rd=%0d expected %0d each", tag, wr_seen, rd_seen, N);
        end
        @(negedge clk);
        n_checks++;
        if (obs() !== model_out(0, 0, 0)) begin
            n_fail++;
            $display("FAIL %s post_done: got %b expected %b", tag, obs(), model_out(0, 0, 0));
        end
    endtask

    task automatic test_write_read();
        run_frame("full_rate", 100, 100, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < 3; i++) run_frame("gaps", 50, 50, -1, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        run_frame("abort", 100, 100, N + 4, 1'b0, 1'b0);
        run_frame("restart", 100, 100, -1, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_write();
        run_frame("rst_mid", 100, 100, 1 * C + 2, 1'b1, 1'b0);
        run_frame("after_rst", 70, 70, -1, 1'b0, 1'b1);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        repeat (2) begin
            n_checks++;
            if (obs() !== model_out(0, 0, 0)) begin
                n_fail++;
                $display("FAIL start_abort_idle: got %b expected %b", obs(), model_out(0, 0, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_defaults();
        int wr, rd, first11, multi, cyc;
        wr = 0; rd = 0; first11 = -1; multi = 0; cyc = 0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        while (!b_done && cyc < 1000) begin
            if ($countones(b_row_sel) > 1) multi++;
            if (b_in_valid && b_in_ready) begin
                if (b_row_sel[11] && first11 < 0) first11 = wr;
                wr++;
            end
            if (b_out_valid && b_out_ready) rd++;
            @(negedge clk);
            cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        n_checks++;
        if (b_done !== 1'b1) begin
            n_fail++;
            $display("FAIL big_done: got %b expected 1 within budget", b_done);
        end
        n_checks++;
        if (wr != BN || rd != BN) begin
            n_fail++;
            $display("FAIL big_beats: got wr=%0d rd=%0d expected %0d each", wr, rd, BN);
        end
        n_checks++;
        if (first11 != (BR - 1) * BC) begin
            n_fail++;
            $display("FAIL big_row11_first: got %0d expected %0d", first11, (BR - 1) * BC);
        end
        n_checks++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL big_onehot: got %0d multi-hot cycles expected 0", multi);
        end
        @(negedge clk);
        n_checks++;
        if ({b_busy, b_done, b_row_sel, b_col_idx} !== '0) begin
            n_fail++;
            $display("FAIL big_idle: got busy=%b done=%b row_sel=%b col=%0d expected zero",
                     b_busy, b_done, b_row_sel, b_col_idx);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_random_gaps();
        test_abort();
        test_rst_mid_write();
        test_start_abort_idle();
        test_defaults();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interleaver_sel_seq.md
INTERLEAVER_SEL_SEQ -- requirements
Module: interleaver_sel_seq

Interface
REQ-001 The block SHALL have parameter ROWS, default 12: number of interleaver rows, 2..16.
REQ-002 The block SHALL have parameter COLS, default 8: number of interleaver columns, 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begins one frame when sampled high in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous return to IDLE.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream symbol present (write phase).
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a symbol (write phase).
REQ-009 The block SHALL have port out_valid, output, 1 bit: the current address is a valid read (read phase).
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the read.
REQ-011 The block SHALL have port row_sel, output, ROWS bits: one-hot row enable; bit r selects row r.
REQ-012 The block SHALL have port col_idx, output, CW=$clog2(COLS) bits: current column index.
REQ-013 The block SHALL have port mode, output, 1 bit: 0 = write (row-major fill), 1 = read (column-major drain).
REQ-014 The block SHALL have ports busy (high outside IDLE) and done (1-cycle pulse), output, 1 bit each.

Function
REQ-015 The FSM SHALL have three states: IDLE, WRITE and READ.
REQ-016 In IDLE, row_sel SHALL be all zero, col_idx 0, in_ready 0, out_valid 0 and mode 0.
REQ-017 IDLE SHALL go to WRITE on start=1, with row pointer r=0 and column pointer c=0.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 In WRITE, in_ready SHALL be 1, row_sel SHALL be one-hot at bit r, col_idx SHALL equal c and mode SHALL be 0.
REQ-020 In WRITE, on in_valid&in_ready: if c<COLS-1 then c increments; otherwise c goes to 0 and r increments.
REQ-021 The beat at r=ROWS-1, c=COLS-1 SHALL enter READ with r=0, c=0.
REQ-022 In READ, out_valid SHALL be 1 and mode SHALL be 1.
REQ-023 In READ, on out_valid&out_ready: if r<ROWS-1 then r increments; otherwise r goes to 0 and c increments (column-major order).
REQ-024 The read beat at r=ROWS-1, c=COLS-1 SHALL return to IDLE and pulse done for exactly the following cycle.
REQ-025 row_sel and col_idx SHALL be registered, with zero combinational path from in_valid or out_ready to the address outputs.
REQ-026 Handshake inputs held low SHALL stall the pointers; outputs SHALL hold indefinitely.
REQ-027 A frame SHALL take exactly ROWS*COLS accepted write beats plus ROWS*COLS accepted read beats, with no beats lost or duplicated.
REQ-028 abort=1 SHALL force IDLE state and outputs next cycle and SHALL NOT pulse done.
REQ-029 abort SHALL have priority over start and over any handshake in the same cycle.
REQ-030 start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-031 row_sel SHALL never have more than one bit set.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, r=0, c=0, row_sel=0, col_idx=0, mode=0, in_ready=0, out_valid=0, busy=0 and done=0.
REQ-033 rst SHALL have priority over abort, start and handshakes, including mid-frame.
REQ-034 The first frame after rst deasserts SHALL require a fresh start.

Structure
REQ-035 The shared interleaver package SHALL hold the state enum (IDLE/WRITE/READ) and the default ROWS=12 and COLS=8 constants.
REQ-036 One sub-module, onehot_dec, SHALL be used: a parametrised binary-to-one-hot decoder of width ROWS with an enable, whose output is all zero when disabled or when the index is >= ROWS.
REQ-037 The row and column pointers SHALL be plain counters in the top module, and onehot_dec SHALL be placed ahead of the row_sel register.

Verification (ROWS=3, COLS=4 unless noted)
REQ-038 Scenario: start, then in_valid held high -> write sequence of (row_sel, col_idx) is 001/0,001/1,001/2,001/3,010/0,...,100/3, giving 12 beats, then mode=1.
REQ-039 Scenario: read with out_ready high -> sequence is 001/0,010/0,100/0,001/1,...,100/3, then done high for 1 cycle, then busy=0 and row_sel=000.
REQ-040 Scenario: random in_valid/out_ready gaps (50%) -> same address order, exactly 24 accepted beats, outputs stable during stalls.
REQ-041 Scenario: abort at the 5th read beat -> next cycle in IDLE, no done pulse; a new start restarts at 001/0 in write mode.
REQ-042 Scenario: rst during the WRITE beat at r=1, c=2 -> all outputs zero next cycle; start while busy is ignored and the frame length is unchanged.
REQ-043 Scenario: defaults ROWS=12, COLS=8 -> 96+96 beats, with the one-hot row_sel bit 11 first seen at write beat 88.
